// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, line/frame total helpers and the pixel coordinate type.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int COORD_LIMIT = 1024;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  function automatic int h_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int v_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate bus from the sync generator to the pattern/RGB consumers.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   en;
  logic   pclk_tick;
  coord_t x_pixel;
  coord_t y_pixel;
  logic   DE;
  logic   h_sync;
  logic   v_sync;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  en,
    output pclk_tick, x_pixel, y_pixel, DE, h_sync, v_sync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );

  modport slave (
    output en,
    input  pclk_tick, x_pixel, y_pixel, DE, h_sync, v_sync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );

endinterface

// File: rtl/vga_pclk_div.sv
// Integer clock-enable divider: one-clk pclk_tick every CLK_DIV clocks while en is high.
module vga_pclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic pclk_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_pclk_div: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt_q <= '0;
    else          div_cnt_q <= div_cnt_d;
  end

  // Gated by reset_n so that CLK_DIV=1 does not tick while held in reset.
  assign pclk_tick = reset_n && en && (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel tick, h/v counters, registered DE/sync/frame_start decode.
// Optional frame counter output when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input logic           clk,
  input logic           reset_n,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
  endgenerate

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // Thresholds are one bit wider than coord_t: a sync end may equal 1024.
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic   tick;
  coord_t h_q, h_d, v_q, v_d;
  logic   de_q, de_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic   frame_start_q, frame_start_d;

  vga_pclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (bus.en),
    .pclk_tick (tick)
  );

  // Decode is taken from the next-state counters so the registered flags line up with x/y.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    de_d          = ({1'b0, h_d} < H_VIS_W) && ({1'b0, v_d} < V_VIS_W);
    h_sync_d      = !(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
    v_sync_d      = !(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
    frame_start_d = tick && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      de_q          <= 1'b0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pclk_tick   = tick;
  assign bus.x_pixel     = h_q;
  assign bus.y_pixel     = v_q;
  assign bus.DE          = de_q;
  assign bus.h_sync      = h_sync_q;
  assign bus.v_sync      = v_sync_q;
  assign bus.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing source that drives the pixel-coordinate interface consumed by the VGA pattern and RGB blocks: x_pixel, y_pixel, DE, plus h_sync/v_sync to the connector.
- Derives a pixel-rate tick from the system clock by integer division.
- Runs horizontal and vertical counters.
- Decodes the visible area and the sync pulses.
- Default timing is 640x480@60 (800x525 total) from a 100 MHz clock with a 25 MHz tick.

Parameters:
CLK_DIV, 4, system clocks per pixel; must be >= 1 (1 = tick every clock)
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  run enable; low freezes divider and counters
pclk_tick  output  1  one-clk pulse at pixel rate
x_pixel  output  10  horizontal counter, 0..H_TOTAL-1
y_pixel  output  10  vertical counter, 0..V_TOTAL-1
DE  output  1  high when x_pixel<H_VISIBLE and y_pixel<V_VISIBLE
h_sync  output  1  active-low horizontal sync
v_sync  output  1  active-low vertical sync
frame_start  output  1  one-clk pulse when counters enter (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
  - Both must be <= 1024; elaboration-time assertion otherwise.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - pclk_tick = en && div_cnt==CLK_DIV-1 (combinational from the register).
  - With CLK_DIV=1, pclk_tick = en.
- Counters advance on the clk edge that ends a pclk_tick cycle:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1 when h also wraps.
- x_pixel/y_pixel are the counter registers directly.
- DE, h_sync, v_sync and frame_start are registered. They are computed from next-state counter values, so they are aligned with x_pixel/y_pixel in the same cycle (zero relative skew).
- Decode rules:
  - h_sync = 0 iff H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
  - v_sync = 0 iff V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491).
- frame_start is high for exactly the one clk in which x,y first equal (0,0). It stays low on non-tick cycles, even though the counters remain (0,0) for CLK_DIV clks.
- Reset values:
  - div_cnt=0.
  - x_pixel=H_TOTAL-1 (799), y_pixel=V_TOTAL-1 (524).
  - DE=0, h_sync=1, v_sync=1, frame_start=0, pclk_tick=0.
  - The first tick after reset therefore enters (0,0) with DE=1 and frame_start=1. No partial first frame.
- en=0:
  - All registers hold; pclk_tick=0.
  - frame_start drops to 0 after one clk; DE and syncs hold their last value.
  - Resuming continues from the held count and div_cnt.
- reset_n asserted mid-frame: all outputs immediately take reset values, asynchronously. Release is sampled on clk.

Optional Feature:
Macro VGA_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0], reset 0, incremented in the same cycle frame_start is set; wraps 65535->0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_timing_pkg:
  - localparams for the 640x480@60 timing set;
  - derived H_TOTAL/V_TOTAL functions;
  - typedef logic [9:0] coord_t, used for x_pixel/y_pixel here and in the RGB consumers.
- One sub-module: vga_pclk_div (CLK_DIV generic divider producing pclk_tick with en).
- Counters and decode stay in vga_sync_gen.

Test Plan:
- Reset, then en=1, defaults:
  - first tick clk+1: x=0, y=0, DE=1, frame_start=1;
  - pclk_tick period 4 clk.
- Line scan:
  - DE high for 640 ticks (2560 clk);
  - h_sync low at x=656 for 96 ticks (384 clk), high again at x=752;
  - x wraps 799->0 with y+1.
- Frame:
  - v_sync low exactly for y=490,491 (1600 ticks);
  - DE=0 for all y>=480;
  - next frame_start 420000 ticks (1,680,000 clk) after the first.
- en dropped at x=100,y=5 for 37 clk:
  - x, y, DE, syncs frozen, no pclk_tick;
  - after resume, x=101 follows within <=4 clk.
- reset_n pulsed at x=300, y=200:
  - outputs immediately 799/524/DE=0/syncs=1;
  - after release, the next frame starts cleanly at (0,0).
- CLK_DIV=1, small timing (H 8/1/2/1, V 4/1/1/1):
  - tick every clk;
  - exact sync/DE positions checked against a reference model;
  - with VGA_FRAME_CNT_EN, frame_cnt=3 after 3 frames.
